quadrature_encoder_emulator: RTL
================================

# quadrature_encoder_emulator

Generates two-channel quadrature signals (A, B) for a commanded number of encoder pulses, direction and edge rate, the transmit-side counterpart of the wheel encoder decoding path. It drives the `A_left`/`B_left` or `A_right`/`B_right` inputs of the wheel interface in hardware-in-the-loop and bench setups, replacing a physical encoder. It exposes a start/busy/done handshake to a controlling FSM and a signed running edge count for cross-checking decoded distance.

## Interface
- `COUNT_WIDTH`, 16, width of the pulse-count command and the remaining-pulses output
- `PERIOD_WIDTH`, 16, width of the edge-period command in clock cycles
- `clk`  input  1  system clock, all state on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  command strobe, sampled only when idle
- `dir`  input  1  1 = CW (A leads B), 0 = CCW (B leads A), latched at accept
- `count`  input  COUNT_WIDTH  full encoder pulses to emit (4 quadrature edges each), latched at accept
- `period`  input  PERIOD_WIDTH  clock cycles between successive quadrature edges, latched at accept; 0 treated as 1
- `abort`  input  1  stop current command
- `A`  output  1  quadrature channel A, registered
- `B`  output  1  quadrature channel B, registered
- `busy`  output  1  command in progress
- `done`  output  1  one-cycle completion or abort strobe
- `aborted`  output  1  last command ended by abort; cleared at next accept
- `pulses_remaining`  output  COUNT_WIDTH  full pulses not yet completed
- `position`  output  32 signed  running edge count, +1 per CW edge, -1 per CCW edge

## Operation
- States: IDLE, RUN. `busy` = 1 exactly in RUN.
- Accept: in IDLE with `start`=1 at edge N. Latch `dir`, `count`, `period` (0→1). Clear `aborted`. Load `pulses_remaining`=`count`, edge timer = period.
- `count`=0 at accept: stay IDLE, `done`=1 at edge N, no A/B activity.
- `start` while busy is ignored. `dir`/`count`/`period` changes during RUN have no effect.
- Phase sequence (A,B): CW 00→10→11→01→00; CCW 00→01→11→10→00. Exactly one of A/B toggles per edge; no glitches, no double toggles.
- Phase persists across commands and after abort. A new command continues from the current phase; it never snaps to 00.
- `position` changes by ±1 on every emitted edge and wraps in two's complement. It is never cleared except by reset.
- `pulses_remaining` decrements on the 4th edge of each pulse, counted from accept and not from absolute phase.
- Completion: on the edge emitting the 4·count-th transition, `pulses_remaining`→0, `busy`→0, `done`→1 for one cycle, and the state returns to IDLE.
- Abort: `abort`=1 at edge M in RUN takes priority over a due transition at M. At edge M: no transition, A/B hold, `busy`→0, `done`=1, `aborted`=1, and `pulses_remaining` holds. `abort` in IDLE is ignored.
- Reset (any time, including mid-run): A=0, B=0, `busy`=0, `done`=0, `aborted`=0, `pulses_remaining`=0, `position`=0, state IDLE, timer 0.

## Timing
- Accept at edge N: `busy`=1 from edge N.
- Transition k (k=1..4·count) is registered at edge N + k·P, where P is the effective period.
- `done` is high in the cycle following edge N + 4·count·P. A `start` in that cycle is accepted, giving back-to-back commands with no idle gap beyond one cycle.
- Minimum P=1 gives one edge per clock, so A and B each have a period of 4 clocks.
- Edge timer width is PERIOD_WIDTH. Total edges per command fit COUNT_WIDTH+2 bits.
- No combinational path from any input to any output.

## Test plan
- Reset, then `start` with dir=1, count=2, period=3 at edge 10 → A/B = 10,11,01,00,10,11,01,00 at edges 13,16,…,34. `done` is high in the cycle after edge 34. position=8, pulses_remaining goes 2→1 at edge 22 and 1→0 at edge 34.
- dir=0, count=1, period=0 → four edges on consecutive clocks in the order 01,11,10,00. position=-4, done after 4 cycles.
- count=0 → `done` one cycle, `busy` never asserts, A/B and position unchanged.
- Abort: dir=1, count=5, period=2, `abort` after 6 edges → A/B hold at 11, pulses_remaining=4, aborted=1, position=6. Next CW command of count=1 starts from 11 and emits 01,00,10,11.
- `start` pulsed mid-run with different dir/count → ignored. Back-to-back `start` in the `done` cycle → accepted, phase continuous.
- Reset asserted mid-run → all outputs go to their reset values immediately, asynchronously. After release, a new command runs normally from 00.

Source files
------------

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature (A/B) pulse generator: emits 4*count edges at a programmable
// edge period with a start/busy/done handshake and a signed edge position.
module quadrature_encoder_emulator #(
    parameter int unsigned COUNT_WIDTH  = 16,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    dir,
    input  logic [COUNT_WIDTH-1:0]  count,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    abort,
    output logic                    A,
    output logic                    B,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [COUNT_WIDTH-1:0]  pulses_remaining,
    output logic signed [31:0]      position
);

    localparam int unsigned POS_WIDTH = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic                         a_q, a_d;
    logic                         b_q, b_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         aborted_q, aborted_d;
    logic                         dir_q, dir_d;
    logic [1:0]                   edge_q, edge_d;
    logic [COUNT_WIDTH-1:0]       rem_q, rem_d;
    logic [PERIOD_WIDTH-1:0]      period_q, period_d;
    logic [PERIOD_WIDTH-1:0]      timer_q, timer_d;
    logic signed [POS_WIDTH-1:0]  pos_q, pos_d;
    logic [PERIOD_WIDTH-1:0]      period_eff_c;

    assign period_eff_c = (period == '0) ? PERIOD_WIDTH'(1) : period;

    // Next-state: accept in IDLE; in RUN, abort beats a due edge.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        dir_d     = dir_q;
        edge_d    = edge_q;
        rem_d     = rem_q;
        period_d  = period_q;
        timer_d   = timer_q;
        pos_d     = pos_q;

        if (state_q == ST_IDLE) begin
            if (start) begin
                dir_d     = dir;
                period_d  = period_eff_c;
                timer_d   = period_eff_c;
                rem_d     = count;
                aborted_d = 1'b0;
                edge_d    = 2'd0;
                if (count == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
        end else begin
            if (abort) begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                aborted_d = 1'b1;
            end else if (timer_q == PERIOD_WIDTH'(1)) begin
                timer_d = period_q;
                // Gray step: CW toggles A when A==B, CCW toggles B when A==B.
                if (dir_q == (a_q == b_q)) begin
                    a_d = ~a_q;
                end else begin
                    b_d = ~b_q;
                end
                pos_d  = dir_q ? POS_WIDTH'(pos_q + 32'sd1) : POS_WIDTH'(pos_q - 32'sd1);
                edge_d = 2'(edge_q + 2'd1);
                if (edge_q == 2'd3) begin
                    rem_d = COUNT_WIDTH'(rem_q - COUNT_WIDTH'(1));
                    if (rem_q == COUNT_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                timer_d = PERIOD_WIDTH'(timer_q - PERIOD_WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            dir_q     <= 1'b0;
            edge_q    <= 2'd0;
            rem_q     <= '0;
            period_q  <= '0;
            timer_q   <= '0;
            pos_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            dir_q     <= dir_d;
            edge_q    <= edge_d;
            rem_q     <= rem_d;
            period_q  <= period_d;
            timer_q   <= timer_d;
            pos_q     <= pos_d;
        end
    end

    assign A                = a_q;
    assign B                = b_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign aborted          = aborted_q;
    assign pulses_remaining = rem_q;
    assign position         = pos_q;

endmodule
